// File: rtl/uart_tx.sv
// UART transmitter, 8N1, with a small transmit FIFO in front of the serialiser.
//
// Parameters:
//   BAUD_DIV   - clk cycles per serial bit (>= 2)
//   FIFO_DEPTH - transmit FIFO entries (power of two, >= 2)
// Ports:
//   clk      - system clock, rising edge active
//   rst_n    - asynchronous active-low reset
//   tx_data  - byte to enqueue
//   tx_valid - tx_data is valid this cycle
//   tx_ready - FIFO can accept a byte this cycle (from registered count only)
//   tx_uart  - registered serial line, idle high
//   busy     - a frame is in progress or the FIFO holds data
module uart_tx #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_uart,
  output logic       busy
);

  localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic              push, pop, fifo_empty, baud_tick;

  assign tx_ready   = (count_q < CntFull);
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid & tx_ready;
  assign baud_tick  = (baud_q == BaudLast);
  assign busy       = (state_q != StIdle) || !fifo_empty;
  assign tx_uart    = tx_q;

  // FIFO storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= tx_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // The line value is computed one cycle ahead so tx_uart is a plain flop and the
  // start bit appears on the same edge that pops the FIFO.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_tick) begin
          baud_d = '0;
          bit_d  = '0;
          if (!fifo_empty) begin
            // Back-to-back frame: no idle bit time between stop and next start.
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      // Power-of-two depth: pointers wrap naturally.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int unsigned BaudDiv = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_uart;
  logic       busy;

  logic [7:0] d_data;
  logic       d_valid;
  logic       d_ready;
  logic       d_uart;
  logic       d_busy;

  int n_checks;
  int n_errors;

  uart_tx #(
    .BAUD_DIV  (16),
    .FIFO_DEPTH(4)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_uart (tx_uart),
    .busy    (busy)
  );

  uart_tx u_dut_def (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (d_data),
    .tx_valid(d_valid),
    .tx_ready(d_ready),
    .tx_uart (d_uart),
    .busy    (d_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int limit, output logic ok);
    int n;
    n = 0;
    while (tx_uart !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    ok = (tx_uart === 1'b0);
  endtask

  // Entered on the first cycle of a start bit; leaves one full frame later.
  task automatic recv(output logic [7:0] b, output logic frame_ok, output logic busy_low);
    logic [9:0] s;
    s        = '0;
    busy_low = 1'b0;
    for (int c = 0; c < 10 * BaudDiv; c++) begin
      if (c % BaudDiv == BaudDiv / 2) s[c / BaudDiv] = tx_uart;
      if (busy !== 1'b1) busy_low = 1'b1;
      step();
    end
    b        = s[8:1];
    frame_ok = (s[0] === 1'b0) && (s[9] === 1'b1);
  endtask

  task automatic push_one(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic       fok, blow, ok, bad;
    int         n_low, n_hi;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    d_valid  = 1'b0;
    d_data   = 8'h00;
    #2 rst_n = 1'b0;
    #10;
    check_eq("rst_tx", tx_uart, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", tx_ready, 1);
    check_eq("rst_def_tx", d_uart, 1);
    repeat (3) step();

    // 0x55, pushed on the first edge after reset release; data changes in flight.
    @(negedge clk);
    rst_n    = 1'b1;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'hAA;
    check_eq("t1_tx_at_e", tx_uart, 1);
    check_eq("t1_busy_at_e", busy, 1);
    step();
    check_eq("t1_start_e1", tx_uart, 0);
    recv(b, fok, blow);
    check_eq("t1_byte", b, 8'h55);
    check_eq("t1_frame", fok, 1);
    check_eq("t1_busy_held", blow, 0);
    check_eq("t1_busy_fall", busy, 0);
    check_eq("t1_idle_tx", tx_uart, 1);
    check_eq("t1_ready", tx_ready, 1);

    // Two bytes on consecutive cycles: back-to-back frames.
    repeat (3) step();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_data  = 8'h3C;
    step();
    tx_valid = 1'b0;
    check_eq("t2_start", tx_uart, 0);
    recv(b, fok, blow);
    check_eq("t2_byte0", b, 8'hA5);
    check_eq("t2_frame0", fok, 1);
    check_eq("t2_busy0", blow, 0);
    check_eq("t2_no_gap", tx_uart, 0);
    recv(b, fok, blow);
    check_eq("t2_byte1", b, 8'h3C);
    check_eq("t2_frame1", fok, 1);
    check_eq("t2_busy1", blow, 0);
    check_eq("t2_busy_fall", busy, 0);

    // tx_valid held high from idle: 5 accepted, then exactly one more after a pop.
    repeat (3) step();
    fork
      begin
        for (int k = 0; k <= 170; k++) begin
          tx_valid = 1'b1;
          if (k <= 4)        tx_data = 8'h10 + 8'(k);
          else if (k == 162) tx_data = 8'h20;
          else               tx_data = 8'hFF;
          if (k == 0)   check_eq("t3_ready_k0", tx_ready, 1);
          if (k == 5)   check_eq("t3_full_k5", tx_ready, 0);
          if (k == 161) check_eq("t3_full_k161", tx_ready, 0);
          if (k == 162) check_eq("t3_ready_k162", tx_ready, 1);
          if (k == 163) check_eq("t3_full_k163", tx_ready, 0);
          step();
        end
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
      begin
        logic [7:0] exp_q [6];
        logic [7:0] rb;
        logic       rok, rfok, rblow;
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h20};
        step();
        wait_start(50, rok);
        check_eq("t3_start_seen", rok, 1);
        for (int f = 0; f < 6; f++) begin
          recv(rb, rfok, rblow);
          check_eq($sformatf("t3_byte%0d", f), rb, exp_q[f]);
          check_eq($sformatf("t3_frame%0d", f), rfok, 1);
        end
        check_eq("t3_busy_fall", busy, 0);
        check_eq("t3_idle_tx", tx_uart, 1);
      end
    join

    // Reset during DATA bit 3 with a second byte still queued.
    repeat (3) step();
    push_one(8'h55);
    push_one(8'h77);
    repeat (70) step();
    check_eq("t4_pre_bit3", tx_uart, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t4_rst_tx", tx_uart, 1);
    check_eq("t4_rst_busy", busy, 0);
    check_eq("t4_rst_ready", tx_ready, 1);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx_uart !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check_eq("t4_no_resume", bad, 0);
    push_one(8'h0F);
    step();
    check_eq("t4_start", tx_uart, 0);
    recv(b, fok, blow);
    check_eq("t4_byte", b, 8'h0F);
    check_eq("t4_frame", fok, 1);
    check_eq("t4_busy_fall", busy, 0);

    // Default divider, byte 0x00: 9 low bit times then one stop bit time.
    d_data  = 8'h00;
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    step();
    check_eq("t5_start", d_uart, 0);
    n_low = 0;
    while (d_uart === 1'b0 && n_low < 60000) begin
      n_low++;
      step();
    end
    check_eq("t5_low_cycles", n_low, 46872);
    n_hi = 0;
    while (d_busy === 1'b1 && n_hi < 10000) begin
      if (d_uart !== 1'b1) n_hi = 20000;
      n_hi++;
      step();
    end
    check_eq("t5_stop_cycles", n_hi, 5208);
    check_eq("t5_idle_tx", d_uart, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
